// File: rtl/store_logic_gen.sv
// Write-side address generator for the Q/K/V buffer: streams one tile of result words into port A.
// Optional macro STORE_BEAT_COUNT_EN adds a saturating total_beats counter output.
module store_logic_gen #(
    parameter int NUM_STORES_PER_TILE = 32,
    parameter int ADDR_WIDTH          = 16,
    parameter int ORIGINAL_COLUMNS    = 768,
    parameter int ORIGINAL_ROWS       = 512,
    parameter int NUM_BITS            = 8,
    parameter int DATA_WIDTH          = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_store,
    input  logic                  reset_addr_counter,
    input  logic [2:0]            Offset_Control,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  store_done,
    output logic                  busy,
    output logic                  cfg_err
`ifdef STORE_BEAT_COUNT_EN
   ,output logic [31:0]           total_beats
`endif
);
    localparam int WORDS_PER_ROW = ORIGINAL_COLUMNS * NUM_BITS / DATA_WIDTH;
    localparam int REGION_WORDS  = ORIGINAL_ROWS * WORDS_PER_ROW;
    localparam int CNT_W         = $clog2(NUM_STORES_PER_TILE + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REGION_WORDS - 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NUM_STORES_PER_TILE - 1);

    typedef enum logic [1:0] {IDLE, STORE, DONE} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr_ctr, r_base, r_bram_addr;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_bram_din;
    logic                  r_bram_en, r_bram_we, r_cfg_err;
    logic                  w_accept, w_start_ok, w_start_bad;
    logic [ADDR_WIDTH-1:0] w_base_sel;

    assign w_accept   = in_valid && (r_state == STORE);
    assign w_base_sel = ADDR_WIDTH'(32'(Offset_Control) * 32'(REGION_WORDS));

    always_comb begin
        w_next      = r_state;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        case (r_state)
            IDLE: if (start_store) begin
                if (Offset_Control <= 3'd4) begin
                    w_start_ok = 1'b1;
                    w_next     = STORE;
                end else begin
                    w_start_bad = 1'b1;
                end
            end
            STORE: if (w_accept && r_beat_cnt == LAST_BEAT) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr_ctr  <= '0;
            r_base      <= '0;
            r_beat_cnt  <= '0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cfg_err <= w_start_bad;
            r_bram_en <= w_accept;
            r_bram_we <= w_accept;
            if (w_accept) begin
                r_bram_addr <= r_base + r_addr_ctr;
                r_bram_din  <= in_data;
            end
            if (w_start_ok) begin
                r_base     <= w_base_sel;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            // Clear beats increment so a clear on an accepted beat restarts at 0.
            if (reset_addr_counter)
                r_addr_ctr <= '0;
            else if (w_accept)
                r_addr_ctr <= (r_addr_ctr == LAST_ADDR) ? '0 : r_addr_ctr + 1'b1;
        end
    end

`ifdef STORE_BEAT_COUNT_EN
    logic [31:0] r_total_beats;
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_total_beats <= '0;
        else if (w_accept && r_total_beats != 32'hFFFF_FFFF)
            r_total_beats <= r_total_beats + 1'b1;
    end
    assign total_beats = r_total_beats;
`endif

    assign in_ready   = (r_state == STORE);
    assign store_done = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign bram_en    = r_bram_en;
    assign bram_we    = r_bram_we;
    assign bram_addr  = r_bram_addr;
    assign bram_din   = r_bram_din;
    assign cfg_err    = r_cfg_err;
endmodule

// File: tb/tb_store_logic_gen.sv
// Directed bench for store_logic_gen: default-size instance plus a small instance for region wrap.
module tb_store_logic_gen;
    localparam int NS = 32;

    logic         clk = 1'b0;
    logic         rst_n, start_store, reset_addr_counter, in_valid;
    logic [2:0]   Offset_Control;
    logic [255:0] in_data;
    logic         in_ready, bram_en, bram_we, store_done, busy, cfg_err;
    logic [15:0]  bram_addr;
    logic [255:0] bram_din;

    logic         s_rst_n, s_start, s_clr, s_valid;
    logic [2:0]   s_oc;
    logic [255:0] s_data;
    logic         s_ready, s_en, s_we, s_done, s_busy, s_cfg;
    logic [15:0]  s_addr;
    logic [255:0] s_din;
`ifdef STORE_BEAT_COUNT_EN
    logic [31:0]  total_beats, s_total;
`endif

    store_logic_gen dut (
        .clk(clk), .rst_n(rst_n), .start_store(start_store),
        .reset_addr_counter(reset_addr_counter), .Offset_Control(Offset_Control),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .store_done(store_done), .busy(busy), .cfg_err(cfg_err)
`ifdef STORE_BEAT_COUNT_EN
       ,.total_beats(total_beats)
`endif
    );

    store_logic_gen #(.NUM_STORES_PER_TILE(3), .ORIGINAL_ROWS(4), .ORIGINAL_COLUMNS(64)) dut_s (
        .clk(clk), .rst_n(s_rst_n), .start_store(s_start),
        .reset_addr_counter(s_clr), .Offset_Control(s_oc),
        .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready),
        .bram_en(s_en), .bram_we(s_we), .bram_addr(s_addr), .bram_din(s_din),
        .store_done(s_done), .busy(s_busy), .cfg_err(s_cfg)
`ifdef STORE_BEAT_COUNT_EN
       ,.total_beats(s_total)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int done_cnt = 0, cfg_cnt = 0, enwe_bad = 0, s_done_cnt = 0;
    logic [15:0]  wa[$], sa[$];
    logic [255:0] wd[$], sd[$];

    always @(negedge clk) begin
        if (bram_we) begin wa.push_back(bram_addr); wd.push_back(bram_din); end
        if (s_we) begin sa.push_back(s_addr); sd.push_back(s_din); end
        if (store_done) done_cnt++;
        if (s_done) s_done_cnt++;
        if (cfg_err) cfg_cnt++;
        if (bram_en !== bram_we || s_en !== s_we) enwe_bad++;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 256'(in_ready), 256'(0));
        chk({tag, "_en"},    256'(bram_en), 256'(0));
        chk({tag, "_we"},    256'(bram_we), 256'(0));
        chk({tag, "_addr"},  256'(bram_addr), 256'(0));
        chk({tag, "_din"},   bram_din, 256'(0));
        chk({tag, "_done"},  256'(store_done), 256'(0));
        chk({tag, "_busy"},  256'(busy), 256'(0));
        chk({tag, "_cfg"},   256'(cfg_err), 256'(0));
    endtask

    // Runs one tile from IDLE; optional start poke at cycle poke_at and clear on beat clr_at.
    task automatic run_tile(input logic [2:0] oc, input bit gappy, input int poke_at, input int clr_at);
        bit [6:0] pat = 7'b1011001;
        int n = 0, cyc = 0;
        logic v, rdy;
        wa.delete(); wd.delete(); done_cnt = 0;
        start_store = 1'b1; Offset_Control = oc;
        @(posedge clk); #1;
        start_store = 1'b0; Offset_Control = 3'd7;
        while (n < NS && cyc < 400) begin
            v = gappy ? pat[cyc % 7] : 1'b1;
            in_valid = v; in_data = 256'(n);
            start_store = (cyc == poke_at);
            reset_addr_counter = v && (n == clr_at);
            rdy = in_ready;
            @(posedge clk); #1;
            if (v && rdy) n++;
            cyc++;
        end
        in_valid = 1'b0; start_store = 1'b0; reset_addr_counter = 1'b0;
        chk("tile_beats", 256'(n), 256'(NS));
        chk("done_with_last_write", 256'({store_done, bram_we, in_ready}), 256'(3'b110));
        @(posedge clk); #1;
        chk("done_one_cycle", 256'({store_done, busy}), 256'(0));
        chk("write_count", 256'(wa.size()), 256'(NS));
        chk("done_count", 256'(done_cnt), 256'(1));
    endtask

    task automatic chk_writes(input string tag, input int base, input int off, input int clr_at);
        int exp;
        for (int i = 0; i < wa.size(); i++) begin
            if (clr_at >= 0 && i > clr_at) exp = base + (i - clr_at - 1);
            else exp = base + off + i;
            chk({tag, "_addr"}, 256'(wa[i]), 256'(exp));
            chk({tag, "_din"}, wd[i], 256'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 0; s_rst_n = 0;
        start_store = 0; reset_addr_counter = 0; in_valid = 0; Offset_Control = 0; in_data = '0;
        s_start = 0; s_clr = 0; s_valid = 0; s_oc = 0; s_data = '0;
        repeat (2) @(posedge clk); #1;
        chk_idle_outputs("reset");
`ifdef STORE_BEAT_COUNT_EN
        chk("reset_total", 256'(total_beats), 256'(0));
`endif
        rst_n = 1; s_rst_n = 1;
        @(posedge clk); #1;

        run_tile(3'd1, 1'b0, -1, -1);
        chk_writes("t1", 12288, 0, -1);

        cfg_cnt = 0;
        run_tile(3'd1, 1'b0, 5, -1);
        chk_writes("t2", 12288, 32, -1);
        chk("start_in_store_no_err", 256'(cfg_cnt), 256'(0));

        reset_addr_counter = 1'b1;
        @(posedge clk); #1;
        reset_addr_counter = 1'b0;
        run_tile(3'd2, 1'b1, -1, -1);
        chk_writes("gappy", 24576, 0, -1);

        wa.delete(); cfg_cnt = 0;
        start_store = 1'b1; Offset_Control = 3'd5;
        @(posedge clk); #1;
        start_store = 1'b0;
        chk("cfg_err_pulse", 256'({cfg_err, busy, in_ready}), 256'(3'b100));
        @(posedge clk); #1;
        chk("cfg_err_clear", 256'({cfg_err, busy}), 256'(0));
        chk("cfg_no_writes", 256'(wa.size()), 256'(0));
        chk("cfg_err_count", 256'(cfg_cnt), 256'(1));

        wa.delete(); done_cnt = 0;
        start_store = 1'b1; Offset_Control = 3'd3;
        @(posedge clk); #1;
        start_store = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 256'(i);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_idle_outputs("midrst");
        chk("midrst_partial_writes", 256'(wa.size()), 256'(10));
`ifdef STORE_BEAT_COUNT_EN
        chk("midrst_total", 256'(total_beats), 256'(0));
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_no_done", 256'(done_cnt), 256'(0));
        run_tile(3'd0, 1'b0, -1, -1);
        chk_writes("after_rst", 0, 0, -1);
`ifdef STORE_BEAT_COUNT_EN
        chk("total_one_tile", 256'(total_beats), 256'(32));
`endif

        run_tile(3'd4, 1'b0, -1, 2);
        chk_writes("clr_on_beat", 49152, 32, 2);

        for (int t = 0; t < 3; t++) begin
            s_start = 1'b1; s_oc = 3'd0;
            @(posedge clk); #1;
            s_start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                s_valid = 1'b1; s_data = 256'(t * 3 + k);
                @(posedge clk); #1;
            end
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("small_write_count", 256'(sa.size()), 256'(9));
        chk("small_done_count", 256'(s_done_cnt), 256'(3));
        for (int i = 0; i < sa.size(); i++) begin
            chk("small_addr", 256'(sa[i]), 256'(i % 8));
            chk("small_din", sd[i], 256'(i));
        end

        chk("en_matches_we", 256'(enwe_bad), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
